// File: rtl/pifo_calendar_shift_queue.sv
// Root PIFO calendar: shift-register priority queue ordered by rank.
// Head (slot 0) is registered and drives the bypass checker directly.
module pifo_calendar_shift_queue #(
  parameter int PIFO_ROOT_WIDTH          = 32,
  parameter int ROOT_RANK_START_POS      = 12,
  parameter int ROOT_RANK_END_POS        = 30,
  parameter int ROOT_PIFO_INFO_VALID_POS = 31,
  parameter int DEPTH                    = 8,
  parameter int COUNT_WIDTH              = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_valid,
  input  logic [PIFO_ROOT_WIDTH-1:0] s_axis_pifo_info,
  output logic                       s_axis_ready,
  input  logic                       m_axis_pop,
  output logic                       m_axis_valid,
  output logic [PIFO_ROOT_WIDTH-1:0] m_axis_pifo_info,
  output logic [PIFO_ROOT_WIDTH-1:0] m_axis_pifo_calandar_top,
  output logic [COUNT_WIDTH-1:0]     count,
  output logic [15:0]                drop_cnt
);

  localparam int RW = ROOT_RANK_END_POS - ROOT_RANK_START_POS + 1;
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

  logic [PIFO_ROOT_WIDTH-1:0] slots [DEPTH];
  logic [PIFO_ROOT_WIDTH-1:0] base  [DEPTH];
  logic [PIFO_ROOT_WIDTH-1:0] nxt   [DEPTH];
  logic [DEPTH-1:0]           le;
  logic [RW-1:0]              new_rank;
  logic                       pop_eff;
  logic                       push_req;
  logic                       push_ok;

  assign s_axis_ready = (count < DEPTH_C);
  assign m_axis_pifo_calandar_top = slots[0];

  assign new_rank = s_axis_pifo_info[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
  assign pop_eff  = m_axis_pop && (count != '0);
  assign push_req = s_axis_valid &&
                    s_axis_pifo_info[ROOT_PIFO_INFO_VALID_POS];
  assign push_ok  = push_req && (s_axis_ready || pop_eff);

  // Pop first, then insert into what remains; le marks entries the new one follows.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_eff) begin
        base[i] = (i == DEPTH-1) ? '0 : slots[(i+1) % DEPTH];
      end else begin
        base[i] = slots[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      le[i] = base[i][ROOT_PIFO_INFO_VALID_POS] &&
              (base[i][ROOT_RANK_END_POS:ROOT_RANK_START_POS] <= new_rank);
    end
    nxt[0] = le[0] ? base[0] : s_axis_pifo_info;
    for (int i = 1; i < DEPTH; i++) begin
      if (le[i]) begin
        nxt[i] = base[i];
      end else if (le[i-1]) begin
        nxt[i] = s_axis_pifo_info;
      end else begin
        nxt[i] = base[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      count            <= '0;
      m_axis_valid     <= 1'b0;
      m_axis_pifo_info <= '0;
      drop_cnt         <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= push_ok ? nxt[i] : base[i];
      end
      m_axis_valid <= pop_eff;
      if (pop_eff) begin
        m_axis_pifo_info <= slots[0];
      end
      if (push_ok && !pop_eff) begin
        count <= count + ONE_C;
      end else if (pop_eff && !push_ok) begin
        count <= count - ONE_C;
      end
      if (push_req && !push_ok && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pifo_calendar_shift_queue.sv
// Bench for pifo_calendar_shift_queue: queue model plus directed checks.
// Model compares every negedge; literals pin key results.
module tb_pifo_calendar_shift_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_valid = 1'b0;
  logic [31:0] s_axis_pifo_info = '0;
  logic        s_axis_ready;
  logic        m_axis_pop = 1'b0;
  logic        m_axis_valid;
  logic [31:0] m_axis_pifo_info;
  logic [31:0] m_axis_pifo_calandar_top;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  pifo_calendar_shift_queue dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_valid             (s_axis_valid),
    .s_axis_pifo_info         (s_axis_pifo_info),
    .s_axis_ready             (s_axis_ready),
    .m_axis_pop               (m_axis_pop),
    .m_axis_valid             (m_axis_valid),
    .m_axis_pifo_info         (m_axis_pifo_info),
    .m_axis_pifo_calandar_top (m_axis_pifo_calandar_top),
    .count                    (count),
    .drop_cnt                 (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_info = '0;
  logic [15:0] exp_drop = '0;

  function automatic logic [18:0] rank_of(input logic [31:0] d);
    return d[30:12];
  endfunction

  function automatic logic [31:0] desc(input int rank, input int addr);
    logic [18:0] r;
    logic [11:0] a;
    r = 19'(rank);
    a = 12'(addr);
    return {1'b1, r, a};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_info  = '0;
      exp_drop  = '0;
    end else begin
      automatic bit pop  = m_axis_pop && (q.size() > 0);
      automatic bit req  = s_axis_valid && s_axis_pifo_info[31];
      automatic bit push = req && (q.size() < 8 || pop);
      exp_valid = pop;
      if (pop) begin
        exp_info = q.pop_front();
      end
      if (req && !push && exp_drop != 16'hFFFF) exp_drop = exp_drop + 1;
      if (push) begin
        automatic int pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
          if (rank_of(q[i]) > rank_of(s_axis_pifo_info)) begin
            pos = i;
            break;
          end
        end
        q.insert(pos, s_axis_pifo_info);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_ready", 32'(s_axis_ready), 32'(q.size() < 8));
    chk("m_top", m_axis_pifo_calandar_top, q.size() > 0 ? q[0] : 32'h0);
    chk("m_valid", 32'(m_axis_valid), 32'(exp_valid));
    chk("m_info", m_axis_pifo_info, exp_info);
    chk("m_drop", 32'(drop_cnt), 32'(exp_drop));
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic p);
    s_axis_valid = v;
    s_axis_pifo_info = d;
    m_axis_pop = p;
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
    s_axis_pifo_info = '0;
    m_axis_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, '0, 0);
    chk("rst_top", m_axis_pifo_calandar_top, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(s_axis_ready), 32'd1);
    chk("rst_valid", 32'(m_axis_valid), 32'd0);

    cyc(1, desc(50, 3), 0);
    cyc(1, desc(10, 1), 0);
    cyc(1, desc(30, 2), 0);
    chk("order_top", 32'(m_axis_pifo_calandar_top[30:12]), 32'd10);
    chk("model_head", 32'(rank_of(q[0])), 32'd10);
    cyc(0, '0, 1);
    chk("pop1_v", 32'(m_axis_valid), 32'd1);
    chk("pop1_r", 32'(m_axis_pifo_info[30:12]), 32'd10);
    cyc(0, '0, 1);
    chk("pop2_r", 32'(m_axis_pifo_info[30:12]), 32'd30);
    cyc(0, '0, 1);
    chk("pop3_r", 32'(m_axis_pifo_info[30:12]), 32'd50);
    cyc(0, '0, 0);
    chk("pulse_end", 32'(m_axis_valid), 32'd0);
    chk("drained", 32'(count), 32'd0);

    cyc(1, desc(20, 1), 0);
    cyc(1, desc(20, 2), 0);
    cyc(0, '0, 1);
    chk("fifo_a", 32'(m_axis_pifo_info[11:0]), 32'h001);
    cyc(0, '0, 1);
    chk("fifo_b", 32'(m_axis_pifo_info[11:0]), 32'h002);

    cyc(0, '0, 1);
    chk("empty_pop", 32'(m_axis_valid), 32'd0);
    chk("empty_hold", 32'(m_axis_pifo_info[11:0]), 32'h002);
    cyc(1, 32'h0000_5001, 0);
    chk("inval_cnt", 32'(count), 32'd0);
    chk("inval_drop", 32'(drop_cnt), 32'd0);

    for (int i = 0; i < 8; i++) cyc(1, desc(40 + i, i), 0);
    chk("full_ready", 32'(s_axis_ready), 32'd0);
    cyc(1, desc(99, 9), 0);
    chk("full_drop", 32'(drop_cnt), 32'd1);
    chk("full_cnt", 32'(count), 32'd8);
    chk("full_top", 32'(m_axis_pifo_calandar_top[30:12]), 32'd40);
    cyc(1, desc(5, 5), 1);
    chk("pp_v", 32'(m_axis_valid), 32'd1);
    chk("pp_r", 32'(m_axis_pifo_info[30:12]), 32'd40);
    chk("pp_cnt", 32'(count), 32'd8);
    chk("pp_top", 32'(m_axis_pifo_calandar_top[30:12]), 32'd5);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1);
    chk("last_pop", 32'(m_axis_pifo_info[30:12]), 32'd47);

    cyc(1, desc(9, 1), 1);
    chk("ppe_v", 32'(m_axis_valid), 32'd0);
    chk("ppe_cnt", 32'(count), 32'd1);
    cyc(0, '0, 1);

    cyc(1, desc(3, 1), 0);
    cyc(1, desc(1, 2), 0);
    cyc(1, desc(2, 3), 0);
    cyc(0, '0, 1);
    rst = 1'b1;
    #1;
    chk("arst_v", 32'(m_axis_valid), 32'd0);
    chk("arst_i", m_axis_pifo_info, 32'h0);
    chk("arst_top", m_axis_pifo_calandar_top, 32'h0);
    chk("arst_cnt", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, desc(7, 4), 0);
    chk("post_top", 32'(m_axis_pifo_calandar_top[30:12]), 32'd7);
    repeat (3) cyc(0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pifo_calendar_shift_queue.md
Name: pifo_calendar_shift_queue

Overview:
Root-level PIFO calendar that stores deferred packet descriptors sorted by rank. It supplies the registered calendar-top word that the output-queue bypass checker compares against. Descriptors that are not bypassed are pushed here; the output scheduler pops the lowest-rank descriptor. The block is a shift-register PIFO with ordered insert and head pop.

Parameters:
PIFO_ROOT_WIDTH, 32, descriptor width
ROOT_RANK_START_POS, 12, rank LSB in descriptor
ROOT_RANK_END_POS, 30, rank MSB in descriptor (rank width 19)
ROOT_PIFO_INFO_VALID_POS, 31, descriptor valid bit
DEPTH, 8, calendar slots (power of 2 not required, >=2)
COUNT_WIDTH, 4, width of occupancy count (must hold DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_valid  in  1  push request
s_axis_pifo_info  in  PIFO_ROOT_WIDTH  descriptor to insert
s_axis_ready  out  1  high when count<DEPTH (combinational from state)
m_axis_pop  in  1  dequeue head request
m_axis_valid  out  1  popped descriptor valid, registered
m_axis_pifo_info  out  PIFO_ROOT_WIDTH  popped descriptor, registered
m_axis_pifo_calandar_top  out  PIFO_ROOT_WIDTH  slot 0 content; valid bit 0 when empty
count  out  COUNT_WIDTH  occupancy
drop_cnt  out  16  saturating count of rejected pushes

Behaviour:
- Reset (async, rst=1): all slots cleared to 0, count=0, m_axis_valid=0, m_axis_pifo_info=0, drop_cnt=0, calandar_top=0, s_axis_ready=1.
- Storage: slots 0..DEPTH-1, slot 0 = head (lowest rank). Occupied slots are contiguous from 0 and have the valid bit set. Empty slots are all-zero.
- Ordering: ranks are compared unsigned. A new entry goes after every entry with rank <= its rank, so equal ranks stay FIFO. Slots at and after the insert point shift up by one.
- Push accepted when s_axis_valid=1, descriptor valid bit=1, and (count<DEPTH or an effective pop occurs in the same cycle).
  - Push rejected because full: drop_cnt increments, saturating at 0xFFFF; state is unchanged.
  - Push with descriptor valid bit=0: silently ignored; drop_cnt unchanged.
- Effective pop: m_axis_pop=1 and count>0 at the start of the cycle. Next cycle: m_axis_valid=1, m_axis_pifo_info=old slot 0, slots shift down by one, and the vacated top slot is zeroed.
- Pop when empty: ignored. m_axis_valid=0 next cycle and m_axis_pifo_info holds its previous value.
- m_axis_valid is a one-cycle pulse per effective pop. Pop latency is 1 cycle.
- Push+pop in the same cycle:
  - Pop uses the pre-cycle head.
  - Insert position is computed against the remaining entries (old slots 1..count-1).
  - count is unchanged.
  - The new entry is never returned by that same pop.
  - Push+pop when empty: pop ignored, entry inserted, count=1.
- m_axis_pifo_calandar_top is driven directly from the slot 0 register with no logic after the flop. A push becomes visible on the next cycle, which keeps the bypass checker's one-cycle sync path clean.
- count updates: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Reset mid-operation: everything clears immediately. Any pending pop output is lost.

Test Plan:
- Reset then idle -> calandar_top=0x00000000, count=0, s_axis_ready=1, m_axis_valid=0.
- Push ranks 50, 10, 30 (descriptor = valid|rank<<12|addr), one per cycle -> calandar_top rank=10. Three pops return ranks 10, 30, 50, each with a one-cycle m_axis_valid pulse; count ends at 0.
- Push rank 20 addr 0x001, then rank 20 addr 0x002 -> pops return addr 0x001 then 0x002 (FIFO tie-break).
- Fill all 8 slots, push a 9th with no pop -> s_axis_ready=0, drop_cnt=1, contents unchanged. Push rank 5 with a simultaneous pop when full -> old head is returned, count stays 8, new top rank=5.
- Pop when empty -> m_axis_valid=0. Push with valid bit 0 -> count stays 0 and drop_cnt stays 0.
- Load 3 entries, assert rst for 1 cycle mid-pop -> all outputs 0 immediately. The next push of rank 7 appears at calandar_top one cycle later.
